// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: converts the bit-reversed output stream of the FFT64
// core into natural bin order using a ping-pong (two-bank) buffer. Writes
// land at bit-reversed addresses of the write bank; the completed bank is
// then read out linearly, so back-to-back frames stream without stalls.
// Optional macro FFT_BITREV_REORDER_SOP_EN adds a do_sop output that marks bin 0.
module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
`ifdef FFT_BITREV_REORDER_SOP_EN
  ,
  output logic             do_sop
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = '1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Sample memory: address = {bank, index}, word = {re, im}. Not reset.
  logic [2*WIDTH-1:0] mem_q [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_active_q, rd_active_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;
  logic             do_sop_q, do_sop_d;

  logic               frame_end;
  logic [2*WIDTH-1:0] rd_word;

  assign frame_end = di_en && (wr_cnt_q == LAST);
  assign rd_word   = mem_q[{rd_bank_q, rd_cnt_q}];

  // Store each accepted sample at its bit-reversed slot in the write bank.
  always_ff @(posedge clock) begin
    if (di_en) mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {di_re, di_im};
  end

  // Next-state for write counters, readout sequencing and output registers.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_active_d = rd_active_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    do_en_d     = rd_active_q;
    do_re_d     = do_re_q;
    do_im_d     = do_im_q;
    do_sop_d    = rd_active_q && (rd_cnt_q == '0);

    if (di_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (frame_end) wr_bank_d = ~wr_bank_q;
    end

    if (rd_active_q) begin
      do_re_d  = rd_word[2*WIDTH-1:WIDTH];
      do_im_d  = rd_word[WIDTH-1:0];
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) rd_active_d = 1'b0;
    end

    // A completed frame (re)starts readout of the bank just filled; this
    // overrides the end-of-readout clear so back-to-back frames run gapless.
    if (frame_end) begin
      rd_active_d = 1'b1;
      rd_bank_d   = wr_bank_q;
      rd_cnt_d    = '0;
    end
  end

  // State registers; reset aborts both a partial input frame and any readout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      do_en_q     <= 1'b0;
      do_re_q     <= '0;
      do_im_q     <= '0;
      do_sop_q    <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_active_q <= rd_active_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      do_en_q     <= do_en_d;
      do_re_q     <= do_re_d;
      do_im_q     <= do_im_d;
      do_sop_q    <= do_sop_d;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;
`ifdef FFT_BITREV_REORDER_SOP_EN
  assign do_sop = do_sop_q;
`else
  logic unused_sop;
  assign unused_sop = do_sop_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=64). Inputs are driven and outputs
// recorded on the falling edge; each scenario task checks its own recording.
module tb_fft_bitrev_reorder;
  localparam int W = 16;
  localparam int MAXC = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic di_en = 1'b0;
  logic [W-1:0] di_re = '0, di_im = '0;
  logic do_en;
  logic [W-1:0] do_re, do_im;
  logic do_sop;

  int checks = 0;
  int errors = 0;

  logic         s_en [MAXC];
  logic [W-1:0] s_re [MAXC];
  logic         o_en [MAXC];
  logic [W-1:0] o_re [MAXC];
  logic [W-1:0] o_im [MAXC];
  logic         o_sop[MAXC];

  fft_bitrev_reorder #(.WIDTH(W), .LOG2N(6)) dut (
    .clock(clock), .reset(reset),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im)
`ifdef FFT_BITREV_REORDER_SOP_EN
    , .do_sop(do_sop)
`endif
  );
`ifndef FFT_BITREV_REORDER_SOP_EN
  assign do_sop = 1'b0;
`endif

  always #5 clock = ~clock;

  function automatic int br6(int j);
    int r = 0;
    for (int i = 0; i < 6; i++) if (j[i]) r |= 1 << (5 - i);
    return r;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin s_en[i] = 1'b0; s_re[i] = '0; end
  endtask

  // Each falling edge: record outputs, then present schedule entry c
  // (accepted on the following rising edge). im is always -re.
  task automatic run(int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      o_en[c] = do_en; o_re[c] = do_re; o_im[c] = do_im; o_sop[c] = do_sop;
      di_en = s_en[c]; di_re = s_re[c]; di_im = -s_re[c];
    end
  endtask

  task automatic do_reset();
    di_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #100;
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
      errors++;
      $display("FAIL reset_state: en=%b re=%0d im=%0d, want 0/0/0", do_en, do_re, do_im);
    end
    reset = 1'b0;
  endtask

  // One 64-sample frame, sample k at schedule index k: bin j observed at 65+j.
  task automatic test_single_frame();
    int cnt = 0;
    logic [W-1:0] er;
    do_reset();
    clear_sched();
    for (int k = 0; k < 64; k++) begin s_en[k] = 1'b1; s_re[k] = W'(k); end
    run(140);
    for (int c = 0; c < 140; c++) if (o_en[c] === 1'b1) cnt++;
    checks++;
    if (cnt != 64) begin errors++; $display("FAIL single_en_count: got %0d, want 64", cnt); end
    checks++;
    if (o_en[64] !== 1'b0) begin errors++; $display("FAIL single_early_en: en=%b at 64, want 0", o_en[64]); end
    for (int j = 0; j < 64; j++) begin
      er = W'(br6(j));
      checks++;
      if (o_en[65+j] !== 1'b1 || o_re[65+j] !== er || o_im[65+j] !== -er) begin
        errors++;
        $display("FAIL single_bin%0d: en=%b re=%0d im=%0d, want 1/%0d/%0d",
                 j, o_en[65+j], o_re[65+j], $signed(o_im[65+j]), er, -br6(j));
      end
    end
    checks++;
    if (o_en[129] !== 1'b0 || o_re[129] !== 16'd63) begin
      errors++; $display("FAIL single_idle_hold: en=%b re=%0d, want 0/63", o_en[129], o_re[129]);
    end
  endtask

  // Two frames back to back: outputs at 65..192 without a gap.
  task automatic test_back_to_back();
    int cnt = 0, sops = 0;
    logic [W-1:0] er;
    do_reset();
    clear_sched();
    for (int k = 0; k < 64; k++) begin
      s_en[k] = 1'b1; s_re[k] = W'(k);
      s_en[64+k] = 1'b1; s_re[64+k] = W'(100 + k);
    end
    run(200);
    for (int c = 65; c < 193; c++) if (o_en[c] === 1'b1) cnt++;
    checks++;
    if (cnt != 128 || o_en[64] !== 1'b0 || o_en[193] !== 1'b0) begin
      errors++; $display("FAIL b2b_burst: high=%0d e64=%b e193=%b, want 128/0/0", cnt, o_en[64], o_en[193]);
    end
    for (int j = 0; j < 128; j++) begin
      er = (j < 64) ? W'(br6(j)) : W'(100 + br6(j - 64));
      checks++;
      if (o_re[65+j] !== er || o_im[65+j] !== -er) begin
        errors++; $display("FAIL b2b_out%0d: re=%0d im=%0d, want %0d", j, o_re[65+j], $signed(o_im[65+j]), er);
      end
    end
    checks++;
    if (o_re[128] !== 16'd63 || o_re[129] !== 16'd100) begin
      errors++; $display("FAIL b2b_seam: re=%0d,%0d want 63,100", o_re[128], o_re[129]);
    end
`ifdef FFT_BITREV_REORDER_SOP_EN
    for (int c = 0; c < 200; c++) if (o_sop[c] === 1'b1) sops++;
    checks++;
    if (sops != 2 || o_sop[65] !== 1'b1 || o_sop[129] !== 1'b1) begin
      errors++; $display("FAIL b2b_sop: count=%0d s65=%b s129=%b, want 2/1/1", sops, o_sop[65], o_sop[129]);
    end
`endif
  endtask

  // Three idle cycles after every 5th sample; last sample at index 99.
  task automatic test_gapped();
    int idx = 0, cnt = 0;
    logic [W-1:0] er;
    do_reset();
    clear_sched();
    for (int k = 0; k < 64; k++) begin
      s_en[idx] = 1'b1; s_re[idx] = W'(k); idx++;
      if ((k + 1) % 5 == 0) idx += 3;
    end
    run(180);
    for (int c = 0; c < 180; c++) if (o_en[c] === 1'b1) cnt++;
    checks++;
    if (cnt != 64 || o_en[100] !== 1'b0) begin
      errors++; $display("FAIL gap_burst: high=%0d e100=%b, want 64/0", cnt, o_en[100]);
    end
    for (int j = 0; j < 64; j++) begin
      er = W'(br6(j));
      checks++;
      if (o_en[101+j] !== 1'b1 || o_re[101+j] !== er || o_im[101+j] !== -er) begin
        errors++; $display("FAIL gap_bin%0d: en=%b re=%0d, want 1/%0d", j, o_en[101+j], o_re[101+j], er);
      end
    end
  endtask

  // 40 junk samples, reset, then a fresh frame of 200+k.
  task automatic test_reset_mid_input();
    int early = 0;
    logic [W-1:0] er;
    do_reset();
    clear_sched();
    for (int k = 0; k < 40; k++) begin s_en[k] = 1'b1; s_re[k] = W'(500 + k); end
    run(41);
    do_reset();
    clear_sched();
    for (int k = 0; k < 64; k++) begin s_en[k] = 1'b1; s_re[k] = W'(200 + k); end
    run(135);
    for (int c = 0; c < 65; c++) if (o_en[c] !== 1'b0) early++;
    checks++;
    if (early != 0) begin errors++; $display("FAIL rin_early_en: %0d cycles high, want 0", early); end
    for (int j = 0; j < 64; j++) begin
      er = W'(200 + br6(j));
      checks++;
      if (o_en[65+j] !== 1'b1 || o_re[65+j] !== er || o_im[65+j] !== -er) begin
        errors++; $display("FAIL rin_bin%0d: en=%b re=%0d, want 1/%0d", j, o_en[65+j], o_re[65+j], er);
      end
    end
  endtask

  // Reset asserted mid-cycle while bin 20 is on the outputs.
  task automatic test_reset_mid_readout();
    int spur = 0;
    do_reset();
    clear_sched();
    for (int k = 0; k < 64; k++) begin s_en[k] = 1'b1; s_re[k] = W'(k); end
    run(86);
    checks++;
    if (o_en[85] !== 1'b1 || o_re[85] !== 16'd10) begin
      errors++; $display("FAIL rout_bin20: en=%b re=%0d, want 1/10", o_en[85], o_re[85]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
      errors++; $display("FAIL rout_async: en=%b re=%0d im=%0d, want 0/0/0", do_en, do_re, do_im);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_sched();
    run(80);
    for (int c = 0; c < 80; c++) if (o_en[c] !== 1'b0) spur++;
    checks++;
    if (spur != 0) begin errors++; $display("FAIL rout_resume: %0d cycles high, want 0", spur); end
    clear_sched();
    for (int k = 0; k < 64; k++) begin s_en[k] = 1'b1; s_re[k] = W'(300 + k); end
    run(70);
    checks++;
    if (o_en[64] !== 1'b0 || o_en[65] !== 1'b1 || o_re[65] !== 16'd300 || o_re[66] !== 16'd332) begin
      errors++; $display("FAIL rout_newframe: e64=%b e65=%b re=%0d,%0d want 0/1/300,332",
                         o_en[64], o_en[65], o_re[65], o_re[66]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_reset_mid_input();
    test_reset_mid_readout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the R22SDF FFT64 core. Consumes its bit-reversed-order output stream (do_en/do_re/do_im of the core drive di_en/di_re/di_im here).
- Re-emits each frame in natural bin order 0..N-1 through a ping-pong (double-bank) buffer, so that continuous back-to-back frames stream without stalls.
- No backpressure. The downstream consumer must accept every do_en cycle.

Parameters:
- WIDTH, 16, bit width of each real and imaginary sample.
- LOG2N, 6, log2 of the frame length. N = 2^LOG2N = 64.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- di_en  input  1  input sample valid; one sample accepted per clock edge where it is high.
- di_re  input  WIDTH  input real part, two's complement; passed through unmodified.
- di_im  input  WIDTH  input imaginary part, two's complement.
- do_en  output  1  output sample valid.
- do_re  output  WIDTH  output real part, natural bin order.
- do_im  output  WIDTH  output imaginary part.

Behaviour:
- Storage: 2 banks x N entries of {re, im}. Registers:
  - wr_cnt (LOG2N bits)
  - wr_bank (1 bit)
  - rd_active (1 bit)
  - rd_cnt (LOG2N bits)
  - rd_bank (1 bit)
- Write path:
  - On each edge with di_en=1, the sample is stored at bank[wr_bank][bitrev(wr_cnt)] and wr_cnt increments.
  - bitrev reverses all LOG2N bits; for N=64, input index 1 (000001) goes to address 32 (100000).
- Gaps: while di_en=0, wr_cnt holds. Gaps of any length are allowed mid-frame.
- Frame end: on the edge that accepts the sample with wr_cnt=N-1:
  - wr_cnt wraps to 0 and wr_bank toggles.
  - rd_active<=1, rd_bank<=old wr_bank, rd_cnt<=0.
- Read path:
  - On each edge with rd_active=1: do_re/do_im <= bank[rd_bank][rd_cnt], do_en<=1, rd_cnt increments.
  - On the edge where rd_cnt=N-1 is output, rd_active clears, unless a new frame end occurs on the same edge; see the next item.
- Back-to-back frames: a frame end coincident with the last read of the previous frame reloads rd_active=1, rd_cnt=0 and toggles rd_bank. do_en then stays high with no gap bin N-1 -> bin 0.
- Latency: bin 0 appears with do_en=1 after the first rising edge following the edge that accepted input sample N-1 (1 clock). do_en stays high for exactly N consecutive cycles per frame.
- Idle outputs: when do_en=0, do_re/do_im hold their last value.
- Bank conflict: reading always targets the bank not being written. A frame cannot complete in fewer than N cycles, so readout (N cycles) always finishes first. No overflow is possible at ≤1 sample/cycle.
- Same-address read/write in one cycle cannot occur (different banks).
- Reset, effective immediately regardless of clock:
  - wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0, rd_bank=0.
  - do_en=0, do_re=0, do_im=0.
  - Memory contents are not cleared.
  - A partial input frame is discarded. An in-progress readout is aborted; no further do_en until a new full frame is written.
- Release: the first di_en sample after reset deassertion is index 0 of a new frame.

Optional Feature:
- Macro: FFT_BITREV_REORDER_SOP_EN.
- Defined:
  - Adds output port do_sop (1 bit, reset 0).
  - do_sop=1 exactly on the cycle do_en=1 carries bin 0, otherwise 0.
  - Registered alongside do_en with identical timing.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Single frame: reset for 100 ns, then 64 consecutive di_en cycles with di_re=k, di_im=-k (k=0..63). Expect:
  - do_en high for exactly 64 cycles, starting 1 clock after the edge accepting k=63.
  - Output j has do_re=bitrev6(j), do_im=-bitrev6(j); e.g. j=1 -> 32/-32, j=2 -> 16/-16, j=63 -> 63/-63.
- Back-to-back: 128 continuous di_en cycles (two frames, second frame values +100). Expect:
  - do_en high for 128 unbroken cycles.
  - Bin 0 of frame 2 immediately follows bin 63 of frame 1 with do_re=100.
- Gapped input: same frame as scenario 1, with di_en low for 3 cycles after every 5th sample. Expect identical output order and values, a single 64-cycle do_en burst, and unchanged 1-clock latency.
- Reset mid-input: assert reset after 40 samples, release, then send a full 64-sample frame. Expect no do_en before the new frame completes, and correct output of the new frame only.
- Reset mid-readout: assert reset at output bin 20. Expect:
  - do_en=0, do_re=0, do_im=0 immediately (asynchronously).
  - No resumption after release until a new full frame has been written.
- With FFT_BITREV_REORDER_SOP_EN defined, rerun the back-to-back scenario. Expect do_sop high exactly twice, coincident with bin 0 of each frame (do_re=0 and do_re=100).
